packet_gen: RTL and testbench

//  AXI-Stream packet generator driven by the packet configuration block. On a start

---
 rtl/pktgen_pkg.sv | 25 ++
 rtl/packet_gen_if.sv | 13 +
 rtl/pktgen_lane_fill.sv | 18 +
 rtl/packet_gen.sv | 162 ++++++++++++++++
 tb/tb_packet_gen.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pktgen_pkg.sv
// Shared definitions for the packet generator and its checker: FSM states,
// the largest legal packet length and the last-beat byte-enable rule.
package pktgen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int MAX_LEN    = 9600;
    localparam int KEEP_MAX_W = 256;

    // Low 'rem' bytes enabled; rem==0 means a full beat.
    function automatic logic [KEEP_MAX_W-1:0] keep_mask(input logic [15:0] rem);
        logic [KEEP_MAX_W-1:0] m;
        if (rem == 16'd0) begin
            m = '1;
        end else begin
            m = (KEEP_MAX_W'(1) << rem) - KEEP_MAX_W'(1);
        end
        return m;
    endfunction

endpackage

// File: rtl/packet_gen_if.sv
// AXI-Stream beat bundle between the packet generator and its sink.
interface packet_gen_if #(
    parameter int DW = 512
);
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic            tlast;
    logic            tvalid;
    logic            tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/pktgen_lane_fill.sv
// Expands a 16-bit pattern value v into a full beat whose lane i carries v+i.
module pktgen_lane_fill #(
    parameter int DW = 512
) (
    input  logic [15:0]   v_i,
    output logic [DW-1:0] data_o
);
    import pktgen_pkg::*;

    localparam int LANES = DW / 16;

    always_comb begin
        data_o = '0;
        for (int i = 0; i < LANES; i++) begin
            data_o[16*i +: 16] = v_i + 16'(i);
        end
    end
endmodule

// File: rtl/packet_gen.sv
// AXI-Stream packet generator: on an accepted start it emits packet_count packets
// of packet_len bytes of an incrementing 16-bit lane pattern, with optional gaps.
module packet_gen #(
    parameter int DW      = 512,
    parameter int MAX_LEN = pktgen_pkg::MAX_LEN
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [15:0]  packet_len,
    input  logic [31:0]  packet_count,
    input  logic [15:0]  idle_cycles,
    input  logic [15:0]  initial_value,
    input  logic         start,
    output logic         busy,
    packet_gen_if.master axis
);
    import pktgen_pkg::*;

    localparam int BYTES = DW / 8;
    localparam int LANES = DW / 16;

    state_t                state_q;
    logic                  busy_q;
    logic [31:0]           pkts_left_q;
    logic [15:0]           idle_q;
    logic [15:0]           gap_ctr_q;
    logic [15:0]           beat_ctr_q;
    logic [15:0]           last_idx_q;
    logic [BYTES-1:0]      keep_last_q;
    logic [15:0]           v_q;
    logic [DW-1:0]         tdata_q;
    logic [BYTES-1:0]      tkeep_q;
    logic                  tlast_q;
    logic                  tvalid_q;

    logic                  start_ok;
    logic                  hs;
    logic [15:0]           beats_d;
    logic [15:0]           rem_d;
    logic [KEEP_MAX_W-1:0] keep_start_full_d;
    logic [BYTES-1:0]      keep_start_d;
    logic [15:0]           v_next_d;
    logic [15:0]           fill_v_d;
    logic [DW-1:0]         fill_data_d;
    logic                  first_is_last;
    logic                  next_is_last;
    logic                  unused_keep;

    assign start_ok = start && (state_q == IDLE) && (packet_count != 32'd0) &&
                      (packet_len != 16'd0) && (32'(packet_len) <= 32'(MAX_LEN));
    assign hs       = tvalid_q && axis.tready;

    assign beats_d           = 16'((32'(packet_len) + 32'(BYTES) - 32'd1) / 32'(BYTES));
    assign rem_d             = 16'(32'(packet_len) % 32'(BYTES));
    assign keep_start_full_d = keep_mask(rem_d);
    assign keep_start_d      = keep_start_full_d[BYTES-1:0];
    assign unused_keep       = ^keep_start_full_d[KEEP_MAX_W-1:BYTES];

    assign v_next_d      = v_q + 16'(LANES);
    assign first_is_last = (last_idx_q == 16'd0);
    assign next_is_last  = ((beat_ctr_q + 16'd1) == last_idx_q);

    // v_q always holds the pattern value of the beat on (or about to be on) the bus.
    always_comb begin
        fill_v_d = v_q;
        case (state_q)
            IDLE:    fill_v_d = initial_value;
            SEND:    fill_v_d = v_next_d;
            default: fill_v_d = v_q;
        endcase
    end

    pktgen_lane_fill #(.DW(DW)) u_fill (
        .v_i    (fill_v_d),
        .data_o (fill_data_d)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            pkts_left_q <= '0;
            idle_q      <= '0;
            gap_ctr_q   <= '0;
            beat_ctr_q  <= '0;
            last_idx_q  <= '0;
            keep_last_q <= '0;
            v_q         <= '0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q     <= SEND;
                        busy_q      <= 1'b1;
                        pkts_left_q <= packet_count;
                        idle_q      <= idle_cycles;
                        last_idx_q  <= beats_d - 16'd1;
                        keep_last_q <= keep_start_d;
                        v_q         <= initial_value;
                        beat_ctr_q  <= '0;
                        tvalid_q    <= 1'b1;
                        tdata_q     <= fill_data_d;
                        tlast_q     <= (beats_d == 16'd1);
                        tkeep_q     <= (beats_d == 16'd1) ? keep_start_d : '1;
                    end
                end
                SEND: begin
                    if (hs) begin
                        v_q <= v_next_d;
                        if (tlast_q) begin
                            beat_ctr_q <= '0;
                            if (pkts_left_q == 32'd1) begin
                                state_q  <= IDLE;
                                busy_q   <= 1'b0;
                                tvalid_q <= 1'b0;
                                tlast_q  <= 1'b0;
                            end else begin
                                pkts_left_q <= pkts_left_q - 32'd1;
                                if (idle_q != 16'd0) begin
                                    state_q   <= GAP;
                                    gap_ctr_q <= idle_q;
                                    tvalid_q  <= 1'b0;
                                    tlast_q   <= 1'b0;
                                end else begin
                                    tdata_q <= fill_data_d;
                                    tlast_q <= first_is_last;
                                    tkeep_q <= first_is_last ? keep_last_q : '1;
                                end
                            end
                        end else begin
                            beat_ctr_q <= beat_ctr_q + 16'd1;
                            tdata_q    <= fill_data_d;
                            tlast_q    <= next_is_last;
                            tkeep_q    <= next_is_last ? keep_last_q : '1;
                        end
                    end
                end
                GAP: begin
                    gap_ctr_q <= gap_ctr_q - 16'd1;
                    if (gap_ctr_q == 16'd1) begin
                        state_q  <= SEND;
                        tvalid_q <= 1'b1;
                        tdata_q  <= fill_data_d;
                        tlast_q  <= first_is_last;
                        tkeep_q  <= first_is_last ? keep_last_q : '1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign axis.tdata  = tdata_q;
    assign axis.tkeep  = tkeep_q;
    assign axis.tlast  = tlast_q;
    assign axis.tvalid = tvalid_q;
endmodule

// File: tb/tb_packet_gen.sv
// Directed and randomized bench for packet_gen against a beat-list reference model.
module tb_packet_gen;
    localparam int DW    = 512;
    localparam int BYTES = DW / 8;
    localparam int LANES = DW / 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] packet_len;
    logic [31:0] packet_count;
    logic [15:0] idle_cycles;
    logic [15:0] initial_value;
    logic        start;
    logic        busy;

    packet_gen_if #(.DW(DW)) axis ();

    packet_gen #(.DW(DW)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .packet_len    (packet_len),
        .packet_count  (packet_count),
        .idle_cycles   (idle_cycles),
        .initial_value (initial_value),
        .start         (start),
        .busy          (busy),
        .axis          (axis.master)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0]    exp_d[$];
    logic [BYTES-1:0] exp_k[$];
    logic             exp_l[$];
    logic [DW-1:0]    obs_d[$];
    logic [BYTES-1:0] obs_k[$];
    logic             obs_l[$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, DW'(axis.tvalid), '0);
        chk({tag, "_busy"},   DW'(busy), '0);
        chk({tag, "_tlast"},  DW'(axis.tlast), '0);
        chk({tag, "_tdata"},  axis.tdata, '0);
        chk({tag, "_tkeep"},  DW'(axis.tkeep), '0);
    endtask

    // Reference: list every beat of the run from the length/count/seed rules.
    task automatic build_model(input int len, input int cnt, input logic [15:0] init);
        int               beats;
        int               rem;
        logic [15:0]      v;
        logic [DW-1:0]    d;
        logic [BYTES-1:0] k;
        exp_d.delete(); exp_k.delete(); exp_l.delete();
        obs_d.delete(); obs_k.delete(); obs_l.delete();
        beats = (len + BYTES - 1) / BYTES;
        rem   = len % BYTES;
        v     = init;
        for (int p = 0; p < cnt; p++) begin
            for (int b = 0; b < beats; b++) begin
                for (int i = 0; i < LANES; i++) d[16*i +: 16] = v + 16'(i);
                k = '1;
                if (b == beats - 1 && rem != 0) k = (BYTES'(1) << rem) - BYTES'(1);
                exp_d.push_back(d);
                exp_k.push_back(k);
                exp_l.push_back(b == beats - 1);
                v = v + 16'(LANES);
            end
        end
    endtask

    task automatic run(input int len, input int cnt, input int idle, input logic [15:0] init,
                       input int pct, input int inject_cyc, input int reset_cyc);
        logic [DW-1:0]    pd;
        logic [BYTES-1:0] pk;
        logic             pl;
        logic             pstall;
        logic             last_seen;
        logic             rdy;
        int               gap_cnt;
        int               budget;
        bit               done;
        build_model(len, cnt, init);
        budget        = 20 * exp_d.size() + cnt * (idle + 2) + 20;
        packet_len    = 16'(len);
        packet_count  = 32'(cnt);
        idle_cycles   = 16'(idle);
        initial_value = init;
        start         = 1'b1;
        @(negedge clk);
        start         = 1'b0;
        packet_len    = 16'($urandom);
        packet_count  = $urandom;
        idle_cycles   = 16'($urandom_range(0, 7));
        initial_value = 16'($urandom);
        pstall = 1'b0; last_seen = 1'b0; gap_cnt = 0; done = 1'b0;
        pd = '0; pk = '0; pl = 1'b0;
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            if (cyc == reset_cyc) begin
                resetn = 1'b0;
                #1;
                chk_reset_outputs("midrst");
                @(negedge clk);
                resetn = 1'b1;
                exp_d.delete(); exp_k.delete(); exp_l.delete();
                return;
            end
            chk("busy", DW'(busy), DW'(exp_d.size() != 0));
            if (pstall) begin
                chk("stall_tvalid", DW'(axis.tvalid), DW'(1));
                chk("stall_tdata",  axis.tdata, pd);
                chk("stall_tkeep",  DW'(axis.tkeep), DW'(pk));
                chk("stall_tlast",  DW'(axis.tlast), DW'(pl));
            end else if (axis.tvalid) begin
                if (exp_d.size() == 0) begin
                    chk("extra_beat", DW'(1), DW'(0));
                end else begin
                    chk("tdata", axis.tdata, exp_d[0]);
                    chk("tkeep", DW'(axis.tkeep), DW'(exp_k[0]));
                    chk("tlast", DW'(axis.tlast), DW'(exp_l[0]));
                end
                if (last_seen) begin
                    chk("gap_len", DW'(gap_cnt), DW'(idle));
                    last_seen = 1'b0;
                end
            end
            if (!axis.tvalid && last_seen) gap_cnt++;
            rdy = ($urandom_range(0, 99) < pct);
            if (cyc == inject_cyc) begin
                start = 1'b1; packet_len = 16'd64; packet_count = 32'd7;
                idle_cycles = 16'd0; initial_value = 16'hAAAA;
            end
            axis.tready = rdy;
            if (axis.tvalid && rdy && exp_d.size() != 0) begin
                obs_d.push_back(axis.tdata);
                obs_k.push_back(axis.tkeep);
                obs_l.push_back(axis.tlast);
                if (exp_l[0]) begin
                    last_seen = 1'b1;
                    gap_cnt   = 0;
                end
                void'(exp_d.pop_front()); void'(exp_k.pop_front()); void'(exp_l.pop_front());
            end
            pstall = axis.tvalid && !rdy;
            pd = axis.tdata; pk = axis.tkeep; pl = axis.tlast;
            @(negedge clk);
            start = 1'b0;
            if (exp_d.size() == 0) done = 1'b1;
        end
        if (!done) chk("timeout_beats_left", DW'(exp_d.size()), DW'(0));
        for (int t = 0; t < idle + 3; t++) begin
            chk("tail_tvalid", DW'(axis.tvalid), DW'(0));
            chk("tail_busy",   DW'(busy), DW'(0));
            @(negedge clk);
        end
    endtask

    task automatic try_bad(input int len, input int cnt);
        packet_len    = 16'(len);
        packet_count  = 32'(cnt);
        idle_cycles   = 16'd0;
        initial_value = 16'h4321;
        start         = 1'b1;
        axis.tready   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 4; t++) begin
            chk("ignored_busy",   DW'(busy), DW'(0));
            chk("ignored_tvalid", DW'(axis.tvalid), DW'(0));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [DW-1:0] tmp;
        resetn        = 1'b0;
        start         = 1'b0;
        packet_len    = '0;
        packet_count  = '0;
        idle_cycles   = '0;
        initial_value = '0;
        axis.tready   = 1'b0;
        #1;
        chk_reset_outputs("reset");
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk_reset_outputs("post_reset");

        run(256, 2, 0, 16'h0100, 100, -1, -1);
        tmp = obs_d[4];
        chk("b4_lane0", DW'(tmp[15:0]), DW'(16'h0180));
        chk("b3_tlast", DW'(obs_l[3]), DW'(1));
        chk("b7_tlast", DW'(obs_l[7]), DW'(1));
        chk("b0_tkeep", DW'(obs_k[0]), DW'({BYTES{1'b1}}));

        run(100, 1, 0, 16'h0000, 100, -1, -1);
        tmp = obs_d[1];
        chk("len100_b1_tkeep", DW'(obs_k[1]), DW'(64'h0000000FFFFFFFFF));
        chk("len100_b1_tlast", DW'(obs_l[1]), DW'(1));
        chk("len100_b1_lane0", DW'(tmp[15:0]), DW'(16'd32));

        run(64, 3, 5, 16'h5555, 100, -1, -1);

        run(128, 1, 0, 16'hFFF0, 50, -1, -1);
        tmp = obs_d[0];
        chk("wrap_lane16", DW'(tmp[16*16 +: 16]), DW'(16'h0000));

        try_bad(64, 0);
        try_bad(0, 1);
        try_bad(9601, 1);

        run(640, 2, 2, 16'h2222, 80, 3, -1);

        run(640, 2, 0, 16'h3333, 100, -1, 4);
        run(128, 1, 0, 16'h1234, 100, -1, -1);
        tmp = obs_d[0];
        chk("after_rst_lane0", DW'(tmp[15:0]), DW'(16'h1234));

        for (int r = 0; r < 5; r++) begin
            run($urandom_range(1, 700), $urandom_range(1, 3), $urandom_range(0, 3),
                16'($urandom), $urandom_range(40, 100), -1, -1);
        end
        run(9600, 1, 1, 16'h0007, 90, -1, -1);
        run(1, 2, 1, 16'hFFFF, 70, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
